// File: rtl/wo_reg_write_arbiter_if.sv
// Requester-side and register-side signals of the write-once register arbiter.
interface wo_reg_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16
);
    // Requester bus
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        nack;

    // Register-side pins and status
    logic                      reg_write;
    logic [DATA_W-1:0]         reg_data;
    logic                      locked;
    logic                      busy;

    // Arbiter view
    modport slave (
        input  req,
        input  req_data,
        output gnt,
        output ack,
        output nack,
        output reg_write,
        output reg_data,
        output locked,
        output busy
    );

    // Requester / environment view
    modport master (
        output req,
        output req_data,
        input  gnt,
        input  ack,
        input  nack,
        input  reg_write,
        input  reg_data,
        input  locked,
        input  busy
    );
endinterface

// File: rtl/wo_reg_write_arbiter.sv
// Round-robin arbiter and one-shot write sequencer in front of a single
// write-once configuration register. Tracks the register lock in a shadow
// bit and refuses every write once the lock has been set.
module wo_reg_write_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                  Clk,
    input  logic                  ip_resetn,
    wo_reg_write_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_DONE    = 3'd2,
        S_REJECT  = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win;
    logic               lock_cap;

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [NUM_REQ-1:0] nack_q;
    logic               reg_write_q;
    logic [DATA_W-1:0]  reg_data_q;
    logic               locked_q;
    logic               busy_q;

    // Per-requester view of the flattened data bus
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // Round-robin search starting at rr_ptr, wrapping past NUM_REQ-1
    logic [IDX_W-1:0]   pick_c;
    logic               found_c;
    logic [IDX_W-1:0]   cand_c;
    int unsigned        idx_c;

    always_comb begin
        pick_c  = '0;
        found_c = 1'b0;
        cand_c  = '0;
        idx_c   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_c = 32'(rr_ptr) + k;
            if (idx_c >= NUM_REQ) begin
                idx_c = idx_c - NUM_REQ;
            end
            cand_c = IDX_W'(idx_c);
            if (!found_c && bus.req[cand_c]) begin
                found_c = 1'b1;
                pick_c  = cand_c;
            end
        end
    end

    // Pointer value that follows the current winner
    logic [IDX_W-1:0]   next_ptr_c;

    always_comb begin
        next_ptr_c = '0;
        if (win != IDX_W'(NUM_REQ - 1)) begin
            next_ptr_c = win + IDX_W'(1);
        end
    end

    // Sequencer state, pointer, lock shadow and all registered outputs
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            win         <= '0;
            lock_cap    <= 1'b0;
            gnt_q       <= '0;
            ack_q       <= '0;
            nack_q      <= '0;
            reg_write_q <= 1'b0;
            reg_data_q  <= '0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Pulses and the write strobe default low every cycle
            ack_q       <= '0;
            nack_q      <= '0;
            reg_write_q <= 1'b0;
            reg_data_q  <= '0;

            unique case (state)
                S_IDLE: begin
                    lock_cap <= 1'b0;
                    if (found_c) begin
                        win    <= pick_c;
                        busy_q <= 1'b1;
                        if (!locked_q) begin
                            state       <= S_WRITE;
                            gnt_q       <= NUM_REQ'(1) << pick_c;
                            reg_write_q <= 1'b1;
                            reg_data_q  <= data_arr[pick_c];
                        end else begin
                            state  <= S_REJECT;
                            nack_q <= NUM_REQ'(1) << pick_c;
                        end
                    end
                end

                S_WRITE: begin
                    // Lock request is the LSB of what was actually written
                    lock_cap <= reg_data_q[0];
                    ack_q    <= NUM_REQ'(1) << win;
                    state    <= S_DONE;
                end

                S_DONE: begin
                    locked_q <= locked_q | lock_cap;
                    gnt_q    <= '0;
                    rr_ptr   <= next_ptr_c;
                    state    <= S_RELEASE;
                end

                S_REJECT: begin
                    rr_ptr <= next_ptr_c;
                    state  <= S_RELEASE;
                end

                S_RELEASE: begin
                    // Hold off until the served requester lets go
                    if (!bus.req[win]) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.nack      = nack_q;
    assign bus.reg_write = reg_write_q;
    assign bus.reg_data  = reg_data_q;
    assign bus.locked    = locked_q;
    assign bus.busy      = busy_q;

`ifndef SYNTHESIS
    // Structural invariants of the sequencer
    a_gnt_onehot : assert property (@(posedge Clk) disable iff (!ip_resetn)
        $onehot0(gnt_q));
    a_resp_onehot : assert property (@(posedge Clk) disable iff (!ip_resetn)
        $onehot0(ack_q | nack_q));
    a_no_write_locked : assert property (@(posedge Clk) disable iff (!ip_resetn)
        reg_write_q |-> !locked_q);
    a_write_only_in_write : assert property (@(posedge Clk) disable iff (!ip_resetn)
        reg_write_q |-> (state == S_WRITE));
`endif

endmodule

// File: tb/tb_wo_reg_write_arbiter.sv
// Scoreboard bench for wo_reg_write_arbiter: directed cases plus random
// request batches checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_wo_reg_write_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int IW      = 2;
    localparam int RD_W    = NUM_REQ * DATA_W;
    localparam int K_WRITE = 0;
    localparam int K_ACK   = 1;
    localparam int K_NACK  = 2;
    localparam int BUDGET  = 400;

    typedef struct {
        int                kind;
        int                idx;
        logic [DATA_W-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;

    wo_reg_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    wo_reg_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .Clk       (clk),
        .ip_resetn (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] onehot(input int i);
        return 32'(1) << i;
    endfunction

    // Reference model state
    ev_t               exp_q[$];
    int                mdl_ptr  = 0;
    bit                mdl_lock = 1'b0;
    logic [DATA_W-1:0] bdata [NUM_REQ];

    // Service order for a set of simultaneously pending requesters
    task automatic model_batch(input logic [NUM_REQ-1:0] mask);
        ev_t e;
        int  start;
        int  idx;
        start = mdl_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (start + k) % NUM_REQ;
            if (mask[IW'(idx)]) begin
                e.idx  = idx;
                e.data = bdata[IW'(idx)];
                if (!mdl_lock) begin
                    e.kind = K_WRITE; exp_q.push_back(e);
                    e.kind = K_ACK;   exp_q.push_back(e);
                    if (e.data[0]) mdl_lock = 1'b1;
                end else begin
                    e.kind = K_NACK;  exp_q.push_back(e);
                end
                mdl_ptr = (idx + 1) % NUM_REQ;
            end
        end
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] mask);
        logic [RD_W-1:0] rd;
        rd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd = rd | (RD_W'(bdata[IW'(i)]) << (i * DATA_W));
        end
        @(negedge clk);
        bus.req_data = rd;
        bus.req      = mask;
    endtask

    task automatic fill_random(input int lock_permille);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < NUM_REQ; i++) begin
            d    = DATA_W'($urandom);
            d[0] = ($urandom_range(999) < lock_permille) ? 1'b1 : 1'b0;
            bdata[IW'(i)] = d;
        end
    endtask

    // Issue a batch; each requester drops its request hold cycles after its response
    task automatic run_batch(input logic [NUM_REQ-1:0] mask, input int hold);
        logic [NUM_REQ-1:0] pend;
        logic [NUM_REQ-1:0] m;
        int                 cnt [NUM_REQ];
        bit                 served [NUM_REQ];
        int                 cyc;
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[IW'(i)]    = 0;
            served[IW'(i)] = 1'b0;
        end
        model_batch(mask);
        drive(mask);
        pend = mask;
        cyc  = 0;
        while ((pend != '0 || bus.busy) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NUM_REQ; i++) begin
                m = NUM_REQ'(1) << i;
                if ((pend & m) != '0) begin
                    if (!served[IW'(i)] && (((bus.ack | bus.nack) & m) != '0)) begin
                        served[IW'(i)] = 1'b1;
                        cnt[IW'(i)]    = hold;
                    end
                    if (served[IW'(i)]) begin
                        if (cnt[IW'(i)] == 0) begin
                            bus.req = bus.req & ~m;
                            pend    = pend & ~m;
                        end else begin
                            cnt[IW'(i)]--;
                        end
                    end
                end
            end
        end
        check("batch_within_budget", 32'(cyc < BUDGET), 32'(1));
        check("batch_queue_drained", 32'(exp_q.size()), 32'(0));
        check("batch_locked", 32'(bus.locked), 32'(mdl_lock));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},       32'(bus.gnt),       32'(0));
        check({tag, "_ack"},       32'(bus.ack),       32'(0));
        check({tag, "_nack"},      32'(bus.nack),      32'(0));
        check({tag, "_reg_write"}, 32'(bus.reg_write), 32'(0));
        check({tag, "_reg_data"},  32'(bus.reg_data),  32'(0));
        check({tag, "_locked"},    32'(bus.locked),    32'(0));
        check({tag, "_busy"},      32'(bus.busy),      32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        exp_q.delete();
        mdl_ptr  = 0;
        mdl_lock = 1'b0;
        @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1;
    endtask

    // Monitor: pop the next expected event whenever the DUT presents one
    ev_t mon_e;
    bit  exp_locked = 1'b0;
    bit  lock_pend  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_locked = 1'b0;
            lock_pend  = 1'b0;
        end else begin
            if (lock_pend) begin
                exp_locked = 1'b1;
                lock_pend  = 1'b0;
            end
            if (bus.reg_write) begin
                check("write_expected", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("write_kind",   32'(K_WRITE),      32'(mon_e.kind));
                    check("write_gnt",    32'(bus.gnt),      onehot(mon_e.idx));
                    check("write_data",   32'(bus.reg_data), 32'(mon_e.data));
                    check("write_locked", 32'(bus.locked),   32'(exp_locked));
                end
            end
            if (bus.ack != '0) begin
                check("ack_expected", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("ack_kind",   32'(K_ACK),      32'(mon_e.kind));
                    check("ack_vec",    32'(bus.ack),    onehot(mon_e.idx));
                    check("ack_gnt",    32'(bus.gnt),    onehot(mon_e.idx));
                    check("ack_locked", 32'(bus.locked), 32'(exp_locked));
                    if (mon_e.data[0]) lock_pend = 1'b1;
                end
            end
            if (bus.nack != '0) begin
                check("nack_expected", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("nack_kind",   32'(K_NACK),        32'(mon_e.kind));
                    check("nack_vec",    32'(bus.nack),      onehot(mon_e.idx));
                    check("nack_nogrant", 32'(bus.gnt),      32'(0));
                    check("nack_nowrite", 32'(bus.reg_write), 32'(0));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t e;
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) bdata[IW'(i)] = '0;
        repeat (2) @(negedge clk);
        check_all_zero("por");
        rst_n = 1'b1;

        // Single write: strobe one cycle after request, ack next, no lock
        bdata[0] = 16'h1234;
        model_batch(4'b0001);
        drive(4'b0001);
        @(negedge clk);
        check("t1_write_pulse", 32'(bus.reg_write), 32'(1));
        check("t1_write_data",  32'(bus.reg_data),  32'h1234);
        @(negedge clk);
        check("t1_ack",        32'(bus.ack),       32'(1));
        check("t1_strobe_low", 32'(bus.reg_write), 32'(0));
        check("t1_data_low",   32'(bus.reg_data),  32'(0));
        bus.req = '0;
        @(negedge clk);
        check("t1_locked", 32'(bus.locked), 32'(0));
        check("t1_busy",   32'(bus.busy),   32'(1));
        @(negedge clk);
        check("t1_idle", 32'(bus.busy), 32'(0));

        // Round robin: continue from 1, then two full rounds from 0
        fill_random(0);
        run_batch(4'b1110, 0);
        fill_random(0);
        run_batch(4'b1111, 0);
        fill_random(0);
        run_batch(4'b1111, 1);

        // Wrap: serve 3, then 0 must win over 3
        fill_random(0);
        run_batch(4'b1000, 0);
        fill_random(0);
        run_batch(4'b1001, 0);

        // Held request: stays in RELEASE, no second write while held
        fill_random(0);
        model_batch(4'b0001);
        drive(4'b0001);
        repeat (2) @(negedge clk);
        check("held_ack", 32'(bus.ack), 32'(1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("held_busy",    32'(bus.busy),      32'(1));
            check("held_nowrite", 32'(bus.reg_write), 32'(0));
        end
        bus.req = '0;
        repeat (2) @(negedge clk);
        check("held_released", 32'(bus.busy), 32'(0));

        // Reset during WRITE: outputs clear immediately, pointer back to 0
        fill_random(0);
        run_batch(4'b0010, 0);
        bdata[2] = 16'h5A5A;
        e.kind = K_WRITE; e.idx = 2; e.data = 16'h5A5A;
        exp_q.push_back(e);
        drive(4'b0100);
        @(negedge clk);
        check("mid_write_pulse", 32'(bus.reg_write), 32'(1));
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid");
        exp_q.delete();
        mdl_ptr  = 0;
        mdl_lock = 1'b0;
        bus.req  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        fill_random(0);
        run_batch(4'b1010, 0);

        // Lock via requester 2, then requester 1 refused next cycle
        fill_random(0);
        bdata[2] = 16'hABCD;
        run_batch(4'b0100, 0);
        model_batch(4'b0010);
        drive(4'b0010);
        @(negedge clk);
        check("lock_nack",    32'(bus.nack),      32'(2));
        check("lock_nowrite", 32'(bus.reg_write), 32'(0));
        bus.req = '0;
        repeat (2) @(negedge clk);
        check("lock_idle", 32'(bus.busy), 32'(0));
        for (int b = 0; b < 3; b++) begin
            fill_random(500);
            run_batch(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, 2));
        end

        // Random batches with occasional lock writes and periodic resets
        for (int b = 0; b < 40; b++) begin
            if (b % 10 == 0) do_reset();
            fill_random(60);
            run_batch(NUM_REQ'($urandom_range(1, 15)), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
